// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler: config address map, ctrl bits, frame FSM states, default widths.
package scaler_pkg;

  localparam int SC_IN_RES_W  = 11;
  localparam int SC_OUT_RES_W = 11;

  localparam logic [3:0] ADDR_XBGN   = 4'd0;
  localparam logic [3:0] ADDR_XEND   = 4'd1;
  localparam logic [3:0] ADDR_YBGN   = 4'd2;
  localparam logic [3:0] ADDR_YEND   = 4'd3;
  localparam logic [3:0] ADDR_INXRES = 4'd4;
  localparam logic [3:0] ADDR_INYRES = 4'd5;
  localparam logic [3:0] ADDR_OUTXRES = 4'd6;
  localparam logic [3:0] ADDR_OUTYRES = 4'd7;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_CLRERR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_LOAD,
    ST_CALC,
    ST_ACTIVE
  } state_e;

endpackage

// File: rtl/scaler_cfg_regs.sv
// Software staging bank with write decode and geometry check; copied to the shadow bank on load_i.
module scaler_cfg_regs
  import scaler_pkg::*;
#(
  parameter int INPUT_RES_WIDTH  = SC_IN_RES_W,
  parameter int OUTPUT_RES_WIDTH = SC_OUT_RES_W,
  parameter int CFG_DATA_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfgWrEn_i,
  input  logic [3:0]                  cfgAddr_i,
  input  logic [CFG_DATA_WIDTH-1:0]   cfgWrData_i,
  input  logic                        load_i,
  input  logic                        clrRun_i,
  output logic [INPUT_RES_WIDTH-1:0]  xBgn_o,
  output logic [INPUT_RES_WIDTH-1:0]  xEnd_o,
  output logic [INPUT_RES_WIDTH-1:0]  yBgn_o,
  output logic [INPUT_RES_WIDTH-1:0]  yEnd_o,
  output logic [INPUT_RES_WIDTH-1:0]  inXRes_o,
  output logic [INPUT_RES_WIDTH-1:0]  inYRes_o,
  output logic [OUTPUT_RES_WIDTH:0]   outXRes_o,
  output logic [OUTPUT_RES_WIDTH:0]   outYRes_o,
  output logic                        run_o,
  output logic                        oneShot_o,
  output logic                        clrErr_o,
  output logic                        cfgValid_o
);

  logic [INPUT_RES_WIDTH-1:0] stXBgn_q, stXEnd_q, stYBgn_q, stYEnd_q, stInXRes_q, stInYRes_q;
  logic [OUTPUT_RES_WIDTH:0]  stOutXRes_q, stOutYRes_q;
  logic                       run_q, oneShot_q;
  logic                       unusedData;

  assign unusedData = ^cfgWrData_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      stXBgn_q    <= '0;
      stXEnd_q    <= '0;
      stYBgn_q    <= '0;
      stYEnd_q    <= '0;
      stInXRes_q  <= '0;
      stInYRes_q  <= '0;
      stOutXRes_q <= '0;
      stOutYRes_q <= '0;
      run_q       <= 1'b0;
      oneShot_q   <= 1'b0;
      xBgn_o      <= '0;
      xEnd_o      <= '0;
      yBgn_o      <= '0;
      yEnd_o      <= '0;
      inXRes_o    <= '0;
      inYRes_o    <= '0;
      outXRes_o   <= '0;
      outYRes_o   <= '0;
    end else begin
      if (cfgWrEn_i) begin
        case (cfgAddr_i)
          ADDR_XBGN:    stXBgn_q    <= cfgWrData_i[INPUT_RES_WIDTH-1:0];
          ADDR_XEND:    stXEnd_q    <= cfgWrData_i[INPUT_RES_WIDTH-1:0];
          ADDR_YBGN:    stYBgn_q    <= cfgWrData_i[INPUT_RES_WIDTH-1:0];
          ADDR_YEND:    stYEnd_q    <= cfgWrData_i[INPUT_RES_WIDTH-1:0];
          ADDR_INXRES:  stInXRes_q  <= cfgWrData_i[INPUT_RES_WIDTH-1:0];
          ADDR_INYRES:  stInYRes_q  <= cfgWrData_i[INPUT_RES_WIDTH-1:0];
          ADDR_OUTXRES: stOutXRes_q <= cfgWrData_i[OUTPUT_RES_WIDTH:0];
          ADDR_OUTYRES: stOutYRes_q <= cfgWrData_i[OUTPUT_RES_WIDTH:0];
          ADDR_CTRL: begin
            run_q     <= cfgWrData_i[CTRL_RUN];
            oneShot_q <= cfgWrData_i[CTRL_ONESHOT];
          end
          default: ;
        endcase
      end
      // A finishing one-shot frame overrides a simultaneous software write of run.
      if (clrRun_i) run_q <= 1'b0;
      if (load_i) begin
        xBgn_o    <= stXBgn_q;
        xEnd_o    <= stXEnd_q;
        yBgn_o    <= stYBgn_q;
        yEnd_o    <= stYEnd_q;
        inXRes_o  <= stInXRes_q;
        inYRes_o  <= stInYRes_q;
        outXRes_o <= stOutXRes_q;
        outYRes_o <= stOutYRes_q;
      end
    end
  end

  assign run_o     = run_q;
  assign oneShot_o = oneShot_q;
  assign clrErr_o  = cfgWrEn_i && (cfgAddr_i == ADDR_CTRL) && cfgWrData_i[CTRL_CLRERR];

  assign cfgValid_o = (stXBgn_q < stXEnd_q) && (stYBgn_q < stYEnd_q) &&
                      (stXEnd_q < stInXRes_q) && (stYEnd_q < stInYRes_q) &&
                      (stOutXRes_q != '0) && (stOutYRes_q != '0);

endmodule

// File: rtl/scaler_frame_ctrl.sv
// Frame sequencer: latches geometry on vsync, runs the coefficient settle window, gates input and counts lines.
module scaler_frame_ctrl
  import scaler_pkg::*;
#(
  parameter int INPUT_RES_WIDTH  = SC_IN_RES_W,
  parameter int OUTPUT_RES_WIDTH = SC_OUT_RES_W,
  parameter int CFG_DATA_WIDTH   = 16,
  parameter int COEF_WAIT        = 32,
  parameter int FRAME_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfgWrEn,
  input  logic [3:0]                  cfgAddr,
  input  logic [CFG_DATA_WIDTH-1:0]   cfgWrData,
  input  logic                        iVsyn,
  input  logic                        iHsyn,
  output logic [INPUT_RES_WIDTH-1:0]  xBgn,
  output logic [INPUT_RES_WIDTH-1:0]  xEnd,
  output logic [INPUT_RES_WIDTH-1:0]  yBgn,
  output logic [INPUT_RES_WIDTH-1:0]  yEnd,
  output logic [INPUT_RES_WIDTH-1:0]  inXRes,
  output logic [INPUT_RES_WIDTH-1:0]  inYRes,
  output logic [OUTPUT_RES_WIDTH:0]   outXRes,
  output logic [OUTPUT_RES_WIDTH:0]   outYRes,
  output logic                        coefEn,
  output logic                        inEn,
  output logic                        busy,
  output logic                        cfgErr,
  output logic                        frameErr,
  output logic                        frameDone,
  output logic [FRAME_CNT_WIDTH-1:0]  frameCnt
);

  localparam int WAIT_W = (COEF_WAIT > 1) ? $clog2(COEF_WAIT) : 1;
  localparam int LINE_W = INPUT_RES_WIDTH + 1;

  state_e                     state_q;
  logic                       vsD_q, hsD_q;
  logic                       coefEn_q, inEn_q, busy_q, cfgErr_q, frameErr_q, frameDone_q;
  logic [FRAME_CNT_WIDTH-1:0] frameCnt_q;
  logic [LINE_W-1:0]          lineCnt_q;
  logic [WAIT_W-1:0]          waitCnt_q;

  logic        vsRise, hsRise, frameComplete;
  logic        run, oneShot, clrErr, cfgValid, loadShadow, clrRun;
  logic [LINE_W-1:0] yEndP1;

  assign vsRise        = iVsyn & ~vsD_q;
  assign hsRise        = iHsyn & ~hsD_q;
  assign yEndP1        = {1'b0, yEnd} + LINE_W'(1);
  assign frameComplete = (lineCnt_q == yEndP1);
  assign loadShadow    = (state_q == ST_LOAD);
  assign clrRun        = (state_q == ST_ACTIVE) && frameComplete && oneShot;

  scaler_cfg_regs #(
    .INPUT_RES_WIDTH (INPUT_RES_WIDTH),
    .OUTPUT_RES_WIDTH(OUTPUT_RES_WIDTH),
    .CFG_DATA_WIDTH  (CFG_DATA_WIDTH)
  ) u_cfg_regs (
    .clk        (clk),
    .rst        (rst),
    .cfgWrEn_i  (cfgWrEn),
    .cfgAddr_i  (cfgAddr),
    .cfgWrData_i(cfgWrData),
    .load_i     (loadShadow),
    .clrRun_i   (clrRun),
    .xBgn_o     (xBgn),
    .xEnd_o     (xEnd),
    .yBgn_o     (yBgn),
    .yEnd_o     (yEnd),
    .inXRes_o   (inXRes),
    .inYRes_o   (inYRes),
    .outXRes_o  (outXRes),
    .outYRes_o  (outYRes),
    .run_o      (run),
    .oneShot_o  (oneShot),
    .clrErr_o   (clrErr),
    .cfgValid_o (cfgValid)
  );

  always_ff @(posedge clk) begin
    vsD_q <= iVsyn;
    hsD_q <= iHsyn;
    if (rst) begin
      state_q     <= ST_IDLE;
      coefEn_q    <= 1'b0;
      inEn_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfgErr_q    <= 1'b0;
      frameErr_q  <= 1'b0;
      frameDone_q <= 1'b0;
      frameCnt_q  <= '0;
      lineCnt_q   <= '0;
      waitCnt_q   <= '0;
    end else begin
      frameDone_q <= 1'b0;
      // Clear first so that an error raised in the same cycle survives.
      if (clrErr) begin
        cfgErr_q   <= 1'b0;
        frameErr_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          coefEn_q <= 1'b0;
          inEn_q   <= 1'b0;
          busy_q   <= 1'b0;
          if (run) state_q <= ST_WAIT_VS;
        end
        ST_WAIT_VS: begin
          if (!run) begin
            state_q <= ST_IDLE;
          end else if (vsRise) begin
            if (cfgValid) begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end else begin
              cfgErr_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state_q   <= ST_CALC;
          coefEn_q  <= 1'b1;
          waitCnt_q <= '0;
          lineCnt_q <= '0;
        end
        ST_CALC: begin
          if (waitCnt_q == WAIT_W'(COEF_WAIT - 1)) begin
            state_q <= ST_ACTIVE;
            inEn_q  <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + WAIT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (frameComplete || vsRise) begin
            coefEn_q <= 1'b0;
            inEn_q   <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_WAIT_VS;
          end
          if (frameComplete) begin
            frameDone_q <= 1'b1;
            frameCnt_q  <= frameCnt_q + FRAME_CNT_WIDTH'(1);
            if (oneShot || !run) begin
              state_q <= ST_IDLE;
            end else if (vsRise) begin
              if (cfgValid) begin
                state_q <= ST_LOAD;
                busy_q  <= 1'b1;
              end else begin
                cfgErr_q <= 1'b1;
              end
            end
          end else if (vsRise) begin
            // Early sync aborts the frame and revalidates immediately.
            frameErr_q <= 1'b1;
            if (cfgValid) begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end else begin
              cfgErr_q <= 1'b1;
            end
          end else if (hsRise) begin
            lineCnt_q <= lineCnt_q + LINE_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign coefEn    = coefEn_q;
  assign inEn      = inEn_q;
  assign busy      = busy_q;
  assign cfgErr    = cfgErr_q;
  assign frameErr  = frameErr_q;
  assign frameDone = frameDone_q;
  assign frameCnt  = frameCnt_q;

endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Bench for scaler_frame_ctrl: validity table, hand-written frame sequences, randomized frames against a frame-level model.
module tb_scaler_frame_ctrl;

  localparam int FW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfgWrEn;
  logic [3:0]  cfgAddr;
  logic [15:0] cfgWrData;
  logic        iVsyn, iHsyn;
  logic [10:0] xBgn, xEnd, yBgn, yEnd, inXRes, inYRes;
  logic [11:0] outXRes, outYRes;
  logic        coefEn, inEn, busy, cfgErr, frameErr, frameDone;
  logic [FW-1:0] frameCnt;

  scaler_frame_ctrl #(.FRAME_CNT_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .cfgWrEn(cfgWrEn), .cfgAddr(cfgAddr), .cfgWrData(cfgWrData),
    .iVsyn(iVsyn), .iHsyn(iHsyn),
    .xBgn(xBgn), .xEnd(xEnd), .yBgn(yBgn), .yEnd(yEnd), .inXRes(inXRes), .inYRes(inYRes),
    .outXRes(outXRes), .outYRes(outYRes), .coefEn(coefEn), .inEn(inEn), .busy(busy),
    .cfgErr(cfgErr), .frameErr(frameErr), .frameDone(frameDone), .frameCnt(frameCnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int doneSeen = 0;

  always @(negedge clk) if (frameDone === 1'b1) doneSeen++;

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfgWrEn = 1'b1; cfgAddr = a; cfgWrData = d;
    step(1);
    cfgWrEn = 1'b0;
  endtask

  task automatic cfg_geom(input int xb, input int xe, input int yb, input int ye,
                          input int ix, input int iy, input int ox, input int oy, input int ctrl);
    wr(4'd0, 16'(xb)); wr(4'd1, 16'(xe)); wr(4'd2, 16'(yb)); wr(4'd3, 16'(ye));
    wr(4'd4, 16'(ix)); wr(4'd5, 16'(iy)); wr(4'd6, 16'(ox)); wr(4'd7, 16'(oy));
    wr(4'd8, 16'(ctrl));
  endtask

  task automatic vs_pulse();
    iVsyn = 1'b1; step(2); iVsyn = 1'b0; step(2);
  endtask

  task automatic lines(input int n);
    repeat (n) begin
      iHsyn = 1'b1; step(1); iHsyn = 1'b0; step(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0; step(1);
  endtask

  typedef struct {
    int xb, xe, yb, ye, ix, iy, ox, oy;
    logic valid;
  } vec_t;

  vec_t tbl[10];
  logic [11:0] expOy;
  int base, L, mCnt;
  int xb, xe, yb, ye, ix, iy, ox, oy;
  int sxe, sye, sox;
  logic valid, loaded, mActive, eCfg, eFrm;

  initial begin
    rst = 1'b1; cfgWrEn = 1'b0; cfgAddr = '0; cfgWrData = '0; iVsyn = 1'b0; iHsyn = 1'b0;
    tbl[0] = '{0, 639, 0, 479, 640, 480, 1024, 768, 1'b1};
    tbl[1] = '{0, 700, 0, 479, 640, 480, 1024, 768, 1'b0};
    tbl[2] = '{5, 5, 0, 479, 640, 480, 1024, 768, 1'b0};
    tbl[3] = '{0, 639, 300, 200, 640, 480, 1024, 768, 1'b0};
    tbl[4] = '{0, 639, 0, 480, 640, 480, 1024, 768, 1'b0};
    tbl[5] = '{0, 639, 0, 479, 640, 480, 0, 768, 1'b0};
    tbl[6] = '{0, 639, 0, 479, 640, 480, 1024, 0, 1'b0};
    tbl[7] = '{10, 11, 20, 21, 12, 22, 1, 1, 1'b1};
    tbl[8] = '{0, 639, 0, 479, 640, 480, 16'hF000, 768, 1'b0};
    tbl[9] = '{0, 2046, 0, 2046, 2047, 2047, 4095, 4095, 1'b1};
    step(3);
    rst = 1'b0;

    chk("rst_frameCnt", 32'(frameCnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_coefEn", 32'(coefEn), 0);
    chk("rst_inEn", 32'(inEn), 0);
    chk("rst_cfgErr", 32'(cfgErr), 0);
    chk("rst_frameErr", 32'(frameErr), 0);
    chk("rst_frameDone", 32'(frameDone), 0);
    chk("rst_xEnd", 32'(xEnd), 0);
    chk("rst_outYRes", 32'(outYRes), 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      cfg_geom(tbl[i].xb, tbl[i].xe, tbl[i].yb, tbl[i].ye, tbl[i].ix, tbl[i].iy, tbl[i].ox, tbl[i].oy, 1);
      step(2);
      iVsyn = 1'b1;
      step(1);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_cfgErr", i), 32'(cfgErr), 32'(!tbl[i].valid));
      step(1);
      expOy = tbl[i].valid ? 12'(tbl[i].oy) : 12'd0;
      chk($sformatf("tbl%0d_xEnd", i), 32'(xEnd), tbl[i].valid ? 32'(tbl[i].xe) : 0);
      chk($sformatf("tbl%0d_outYRes", i), 32'(outYRes), 32'(expOy));
      iVsyn = 1'b0;
      step(2);
    end

    // Load timing and settle window.
    do_reset();
    cfg_geom(0, 639, 0, 479, 640, 480, 1024, 768, 1);
    step(2);
    iVsyn = 1'b1;
    step(1);
    chk("shadow_hold_1cyc", 32'(xEnd), 0);
    chk("busy_after_vs", 32'(busy), 1);
    step(1);
    chk("shadow_xEnd", 32'(xEnd), 639);
    chk("shadow_yEnd", 32'(yEnd), 479);
    chk("shadow_outXRes", 32'(outXRes), 1024);
    chk("coefEn_start", 32'(coefEn), 1);
    chk("inEn_in_calc", 32'(inEn), 0);
    iVsyn = 1'b0;
    step(31);
    chk("inEn_calc_end", 32'(inEn), 0);
    step(1);
    chk("inEn_active", 32'(inEn), 1);
    chk("coefEn_active", 32'(coefEn), 1);

    // Line counting.
    lines(479); step(3);
    chk("no_done_479", doneSeen, 0);
    lines(1); step(3);
    chk("done_480", doneSeen, 1);
    chk("frameCnt_1", 32'(frameCnt), 1);
    chk("inEn_dropped", 32'(inEn), 0);
    chk("coefEn_dropped", 32'(coefEn), 0);
    chk("busy_dropped", 32'(busy), 0);

    // Invalid geometry.
    wr(4'd1, 16'd700);
    vs_pulse();
    chk("inval_cfgErr", 32'(cfgErr), 1);
    chk("inval_busy", 32'(busy), 0);
    chk("inval_shadow", 32'(xEnd), 639);
    wr(4'd8, 16'd5);
    chk("clrErr_cfgErr", 32'(cfgErr), 0);
    wr(4'd1, 16'd639);

    // Early vsync.
    vs_pulse(); step(36);
    chk("early_active", 32'(inEn), 1);
    lines(100);
    vs_pulse();
    chk("early_frameErr", 32'(frameErr), 1);
    chk("early_frameCnt", 32'(frameCnt), 1);
    chk("early_reload", 32'(busy), 1);
    step(36);
    lines(479); step(3);
    chk("early_restart_479", doneSeen, 1);
    lines(1); step(3);
    chk("early_restart_480", doneSeen, 2);
    chk("frameCnt_2", 32'(frameCnt), 2);

    // Shadow isolation, vsync during CALC, wrap.
    wr(4'd8, 16'd5);
    chk("clr_frameErr", 32'(frameErr), 0);
    vs_pulse(); vs_pulse(); step(32);
    chk("vs_calc_ignored", 32'(frameErr), 0);
    chk("vs_calc_active", 32'(inEn), 1);
    wr(4'd3, 16'd239);
    lines(479); step(3);
    chk("iso_479", doneSeen, 2);
    lines(1); step(3);
    chk("iso_480", doneSeen, 3);
    chk("frameCnt_3", 32'(frameCnt), 3);
    vs_pulse(); step(36);
    lines(239); step(3);
    chk("short_239", doneSeen, 3);
    lines(1); step(3);
    chk("short_240", doneSeen, 4);
    chk("frameCnt_wrap", 32'(frameCnt), 0);
    chk("short_yEnd", 32'(yEnd), 239);

    // run cleared mid-frame.
    vs_pulse(); step(36);
    wr(4'd8, 16'd0);
    lines(240); step(3);
    chk("runclr_done", doneSeen, 5);
    chk("runclr_frameCnt", 32'(frameCnt), 1);
    vs_pulse(); step(2);
    chk("runclr_idle", 32'(busy), 0);

    // oneShot.
    wr(4'd8, 16'd3); step(2);
    vs_pulse(); step(36);
    lines(240); step(3);
    chk("oneshot_done", doneSeen, 6);
    chk("oneshot_frameCnt", 32'(frameCnt), 2);
    vs_pulse(); step(2);
    chk("oneshot_run_cleared", 32'(busy), 0);

    // Completion and vsync in the same cycle.
    wr(4'd8, 16'd1); step(2);
    vs_pulse(); step(36);
    lines(239);
    iHsyn = 1'b1; step(1); iHsyn = 1'b0; iVsyn = 1'b1; step(1);
    chk("coinc_frameDone", 32'(frameDone), 1);
    chk("coinc_reload", 32'(busy), 1);
    iVsyn = 1'b0; step(3);
    chk("coinc_count", doneSeen, 7);
    chk("coinc_frameCnt", 32'(frameCnt), 3);
    chk("coinc_no_frameErr", 32'(frameErr), 0);
    step(33);
    lines(240); step(3);
    chk("coinc_next_done", doneSeen, 8);
    chk("coinc_wrap", 32'(frameCnt), 0);

    // Randomized frames against a frame-level model.
    do_reset();
    base = doneSeen; mCnt = 0; mActive = 1'b0; sxe = 0; sye = 0; sox = 0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        xb = $urandom_range(0, 50); xe = xb + 1 + $urandom_range(0, 50); ix = xe + 1 + $urandom_range(0, 50);
        yb = $urandom_range(0, 5);  ye = yb + 1 + $urandom_range(0, 8);  iy = ye + 1 + $urandom_range(0, 5);
        ox = $urandom_range(1, 4095); oy = $urandom_range(1, 4095);
      end else begin
        xb = $urandom_range(0, 20); xe = $urandom_range(0, 20); ix = $urandom_range(0, 20);
        yb = $urandom_range(0, 6);  ye = $urandom_range(0, 6);  iy = $urandom_range(0, 6);
        ox = $urandom_range(0, 2);  oy = $urandom_range(0, 2);
      end
      valid = (xb < xe) && (yb < ye) && (xe < ix) && (ye < iy) && (ox != 0) && (oy != 0);
      cfg_geom(xb, xe, yb, ye, ix, iy, ox, oy, 5);
      eCfg = 1'b0; eFrm = 1'b0;
      step(2);
      vs_pulse();
      if (mActive) begin eFrm = 1'b1; mActive = 1'b0; end
      loaded = valid;
      if (valid) begin sxe = xe; sye = ye; sox = ox; end
      else eCfg = 1'b1;
      step(36);
      L = $urandom_range(0, sye + 3);
      lines(L);
      if (loaded) begin
        if (L >= sye + 1) mCnt++;
        else mActive = 1'b1;
      end
      step(3);
      chk($sformatf("rnd%0d_frameCnt", it), 32'(frameCnt), 32'(mCnt % 4));
      chk($sformatf("rnd%0d_doneCnt", it), doneSeen - base, mCnt);
      chk($sformatf("rnd%0d_cfgErr", it), 32'(cfgErr), 32'(eCfg));
      chk($sformatf("rnd%0d_frameErr", it), 32'(frameErr), 32'(eFrm));
      chk($sformatf("rnd%0d_busy", it), 32'(busy), 32'(mActive));
      chk($sformatf("rnd%0d_inEn", it), 32'(inEn), 32'(mActive));
      chk($sformatf("rnd%0d_xEnd", it), 32'(xEnd), sxe);
      chk($sformatf("rnd%0d_yEnd", it), 32'(yEnd), sye);
      chk($sformatf("rnd%0d_outXRes", it), 32'(outXRes), sox);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scaler_frame_ctrl.md
Name: scaler_frame_ctrl

Overview:
Frame-level sequencer for the scaler datapath, in the input clock domain.
- Holds a software-written staging register bank and copies it to shadow outputs on a vertical-sync rising edge, so geometry never changes mid-frame.
- Validates the geometry, enables the coefficient calculator for a fixed settle time, then opens the input-write gate.
- Counts input lines, detects early or late frame sync, and reports status.

Parameters:
INPUT_RES_WIDTH, 11, width of input geometry fields (xBgn..yEnd, inXRes, inYRes)
OUTPUT_RES_WIDTH, 11, output resolution fields are OUTPUT_RES_WIDTH+1 bits
CFG_DATA_WIDTH, 16, config write-data width; fields take the LSBs
COEF_WAIT, 32, cycles coefEn is held before input is enabled (min 1)
FRAME_CNT_WIDTH, 16, frame counter width

Ports:
clk  in  1  input (write-side) clock
rst  in  1  synchronous active-high reset
cfgWrEn  in  1  staging register write strobe
cfgAddr  in  4  0 xBgn, 1 xEnd, 2 yBgn, 3 yEnd, 4 inXRes, 5 inYRes, 6 outXRes, 7 outYRes, 8 ctrl; other addresses ignored
cfgWrData  in  CFG_DATA_WIDTH  write data; ctrl uses bit0 run, bit1 oneShot, bit2 clrErr (self-clearing)
iVsyn  in  1  input field sync, level
iHsyn  in  1  input line sync, level
xBgn,xEnd,yBgn,yEnd,inXRes,inYRes  out  INPUT_RES_WIDTH  shadow geometry
outXRes,outYRes  out  OUTPUT_RES_WIDTH+1  shadow output resolution
coefEn  out  1  enable to the coefficient calculator
inEn  out  1  enable to the input controller
busy  out  1  high in LOAD, CALC or ACTIVE
cfgErr  out  1  sticky: rejected geometry
frameErr  out  1  sticky: vsync arrived during ACTIVE
frameDone  out  1  one-cycle pulse at normal frame completion
frameCnt  out  FRAME_CNT_WIDTH  completed-frame count; wraps to 0

Behaviour:
Reset:
- All staging and shadow registers are 0.
- run=0, oneShot=0.
- coefEn, inEn, busy, cfgErr, frameErr, frameDone = 0; frameCnt = 0.
- State = IDLE.

Edge detection:
- vsD and hsD are registered copies of iVsyn and iHsyn.
- vsRise = iVsyn & ~vsD; hsRise = iHsyn & ~hsD.

Staging writes:
- Take effect at the clock edge after the strobe.
- Never affect shadow outputs directly.
- Writing ctrl with clrErr=1 clears cfgErr and frameErr. A same-cycle set takes priority over the clear.

States:
- IDLE: all enables low. If run=1, go to WAIT_VS.
- WAIT_VS: if run=0, go to IDLE. On vsRise, validate the staging bank.
  - Valid means: xBgn<xEnd, yBgn<yEnd, xEnd<inXRes, yEnd<inYRes, outXRes!=0, outYRes!=0.
  - Valid: go to LOAD.
  - Invalid: set cfgErr and stay in WAIT_VS.
- LOAD: one cycle. Copy staging to shadow at the end of this cycle; clear the line counter. Go to CALC.
  - Shadow outputs change exactly 2 cycles after the cycle in which vsRise is high.
- CALC: coefEn=1 for exactly COEF_WAIT cycles, then go to ACTIVE.
- ACTIVE: inEn=1 and coefEn=1. Each hsRise increments lineCnt (INPUT_RES_WIDTH+1 bits).
  - When lineCnt reaches yEnd+1 (shadow value): pulse frameDone, increment frameCnt, deassert inEn on the next cycle.
  - Next state after completion: if oneShot=1, go to IDLE and clear run. Else if run=1, go to WAIT_VS. Otherwise go to IDLE.

Boundary cases:
- vsRise in ACTIVE before completion: set frameErr, abort the frame (no frameDone, frameCnt unchanged), and re-enter via the WAIT_VS validation path in the same cycle.
- vsRise in LOAD or CALC: ignored.
- vsRise and hsRise in the same cycle in ACTIVE: vsRise wins; the line is not counted.
- Frame completion and vsRise in the same cycle: completion is recorded, then the next frame loads immediately (goes to LOAD if valid).
- run cleared mid-frame: the current frame finishes, then go to IDLE.
- Staging writes during ACTIVE: do not disturb the shadow values.
- rst in any state returns to the reset values on the next edge.
- frameCnt wraps from all-ones to 0.
- All outputs are registered.

Decomposition:
- Shared package scaler_pkg holds:
  - the cfgAddr constants (ADDR_XBGN..ADDR_CTRL);
  - ctrl bit indices;
  - the state encoding (IDLE, WAIT_VS, LOAD, CALC, ACTIVE);
  - the resolution-width localparams reused by coefCal and inputCtrl.
- One natural sub-module: scaler_cfg_regs, holding the staging bank, write decode, validity check and shadow copy. The FSM and counters stay in the top of this block.

Test Plan:
1. Reset then run: write xBgn=0, xEnd=639, yBgn=0, yEnd=479, inXRes=640, inYRes=480, outXRes=1024, outYRes=768, ctrl=1; pulse iVsyn -> shadow updates 2 cycles after vsRise; coefEn high for 32 cycles; then inEn=1.
2. Line counting: in ACTIVE, give 480 iHsyn pulses with yEnd=479 -> frameDone pulses once after the 480th; frameCnt=1; inEn drops; state WAIT_VS.
3. Invalid config: xEnd=700 with inXRes=640, then vsRise -> cfgErr=1, no LOAD, shadow unchanged; ctrl clrErr write -> cfgErr=0.
4. Early vsync: vsRise after 100 lines -> frameErr=1; frameCnt unchanged; reload occurs and lineCnt restarts at 0.
5. Shadow isolation: write yEnd=239 during ACTIVE -> the current frame still ends after 480 lines; the next frame ends after 240.
6. oneShot and wrap: ctrl=3 -> exactly one frame, then IDLE with run=0. Preload near the wrap with FRAME_CNT_WIDTH=2 -> after 4 frames frameCnt=0.
